dma_channel_arbiter: RTL and testbench
======================================

// Module: dma_channel_arbiter
// PURPOSE
//  Per-transfer scheduler for the DMA. Arbitrates channel DREQs by fixed or rotating
//  priority and runs the HRQ/HLDA bus handshake with the CPU. Issues DACK and a
//  per-transfer start pulse to the timing-control block, then releases the bus on
//  single-mode completion, terminal count or EOP. Sits between the channel
//  request/mask logic and the timing control.
// PARAMETERS
//  NUM_CH  4                  number of DMA channels
//  CH_W    $clog2(NUM_CH)     channel index width (derived, not overridden)
// PORTS
//  clk          in   1        clock
//  reset        in   1        asynchronous, active-high reset
//  dreq         in   NUM_CH   channel requests, level, active-high
//  mask         in   NUM_CH   1 = channel ignored by arbitration
//  cmd_disable  in   1        1 = no new arbitration (a service in progress completes)
//  rotate_en    in   1        1 = rotating priority, 0 = fixed (ch0 highest)
//  block_mode   in   NUM_CH   1 = block transfer, 0 = single transfer
//  hrq          out  1        hold request to CPU
//  hlda         in   1        hold acknowledge from CPU
//  dack         out  NUM_CH   one-hot acknowledge to granted channel
//  ch_sel       out  CH_W     encoded granted channel (valid while dack != 0)
//  xfer_start   out  1        1-cycle pulse: timing control starts one transfer
//  xfer_done    in   1        1-cycle pulse: timing control finished one transfer
//  tc           in   1        terminal count of active channel, sampled with xfer_done
//  eop_n        in   1        external end of process, active-low
//  busy         out  1        1 in any state other than IDLE
//  tc_status    out  NUM_CH   sticky per-channel completion (tc or EOP) flags
//  status_rd    in   1        1-cycle pulse clears tc_status
// BEHAVIOUR
//  Reset: state=IDLE, hrq=0, dack=0, ch_sel=0, xfer_start=0, busy=0, tc_status=0,
//    priority pointer=0 (ch0 highest). Reset mid-transfer aborts immediately.
//  eligible = dreq & ~mask. All outputs registered.
//  FSM:
//   IDLE    : if !cmd_disable && |eligible -> REQ; hrq=1 from the next edge.
//   REQ     : hold hrq. On hlda=1:
//             - |eligible: latch winner (re-evaluated this cycle), set dack/ch_sel -> START.
//             - eligible==0: -> RELEASE with no dack.
//   START   : xfer_start=1 for exactly one cycle; dack held -> WAIT.
//   WAIT    : dack held.
//             - eop_n=0 in any WAIT cycle sets an internal eop_seen latch.
//             - On xfer_done: if tc || eop_seen || !eop_n -> set tc_status[ch], -> RELEASE.
//               Else if block_mode[ch] -> START (no re-arbitration, dreq ignored).
//               Else -> RELEASE.
//   RELEASE : hrq=0, dack=0. -> IDLE once hlda=0. eop_seen is cleared.
//  Latency:
//   - request in IDLE -> hrq after 1 clk.
//   - hlda high in REQ -> dack + ch_sel after 1 clk; xfer_start in the same cycle as first dack.
//  Priority:
//   - rotate_en=0: lowest index wins.
//   - rotate_en=1: search starts at pointer. On leaving WAIT the pointer becomes (ch+1) mod
//     NUM_CH, so the served channel becomes lowest priority. The pointer updates on that exit
//     even when rotate_en=0 but is only used when rotate_en=1.
//  hlda dropped in START or WAIT (CPU revoke):
//   - next edge: hrq=0, dack=0, -> IDLE.
//   - no tc_status update; pointer unchanged.
//  mask, cmd_disable and block_mode changes during START/WAIT have no effect until IDLE.
//  tc_status: set and status_rd in the same cycle -> bit is set (set wins over clear).
//  xfer_done outside WAIT is ignored.
// STRUCTURE
//  Package dma_pkg:
//   - NUM_CH default and the arbiter state enum (IDLE, REQ, START, WAIT, RELEASE).
//   - localparam for CH_W.
//  Sub-module dma_prio_encoder: combinational rotating priority encoder
//   (eligible, pointer, rotate_en -> one-hot grant, index, any).
//  All sequential logic lives in dma_channel_arbiter.
// TESTING
//  1 Fixed priority: rotate_en=0, dreq=4'b1010, hlda after 3 clk
//    -> hrq=1; dack=4'b0010, ch_sel=1, one xfer_start pulse.
//  2 Rotation: rotate_en=1, single mode, dreq=4'b1010 held; ch1 served, xfer_done, hlda cycled
//    -> next grant dack=4'b1000 (ch3), then ch1 again.
//  3 Block mode ch2: xfer_done x3, tc=1 on the third
//    -> 3 xfer_start pulses, hrq stays high throughout; tc_status=4'b0100; then release.
//  4 EOP: block mode ch0, eop_n low 1 clk mid-WAIT, tc=0
//    -> release after the current xfer_done; tc_status[0]=1.
//    Same-cycle status_rd -> bit remains 1.
//  5 Revoke: hlda=0 during WAIT
//    -> next clk dack=0, hrq=0, busy=0, tc_status unchanged.
//    Assert reset mid-WAIT -> all outputs 0 asynchronously.
//  6 Gating: dreq=4'b0001 with mask=4'b0001 or cmd_disable=1 -> hrq stays 0.
//    dreq withdrawn before hlda -> no dack, hrq drops, return to IDLE after hlda=0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel arbiter slice.
//   NUM_CH      : default channel count
//   CH_W        : channel index width derived from NUM_CH
//   arb_state_e : arbiter FSM states
package dma_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_START,
    ST_WAIT,
    ST_RELEASE
  } arb_state_e;

endpackage

// File: rtl/dma_prio_encoder.sv
// Combinational priority encoder with an optional rotating start point.
//   eligible  in  NUM_CH  candidate channels
//   pointer   in  CH_W    first channel searched when rotate_en=1
//   rotate_en in  1       0 = ch0 searched first, 1 = search starts at pointer
//   grant     out NUM_CH  one-hot winner (zero when nothing eligible)
//   index     out CH_W    encoded winner (zero when nothing eligible)
//   any       out 1       at least one channel eligible
module dma_prio_encoder
  import dma_pkg::*;
#(
  parameter  int NUM_CH = dma_pkg::NUM_CH,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [CH_W-1:0]   pointer,
  input  logic              rotate_en,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   index,
  output logic              any
);

  always_comb begin
    int  base;
    int  c;
    logic found;
    grant = '0;
    index = '0;
    any   = |eligible;
    base  = rotate_en ? int'(pointer) : 0;
    c     = 0;
    found = 1'b0;
    // Walk the channels in priority order starting at base, wrapping around.
    for (int k = 0; k < NUM_CH; k++) begin
      c = (base + k) % NUM_CH;
      if (!found && eligible[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        index    = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Per-transfer DMA scheduler: arbitrates channel requests, runs the HRQ/HLDA
// hold handshake with the CPU, issues DACK plus a transfer-start pulse to the
// timing control and releases the bus on single completion, TC or EOP.
//   clk, reset    clock, asynchronous active-high reset
//   dreq, mask    channel requests / arbitration masks
//   cmd_disable   blocks new arbitration
//   rotate_en     rotating (1) or fixed (0) priority
//   block_mode    per-channel block (1) / single (0) transfer mode
//   hrq / hlda    hold request / acknowledge
//   dack, ch_sel  one-hot and encoded granted channel
//   xfer_start    1-cycle start pulse; xfer_done/tc/eop_n report completion
//   busy          FSM not idle
//   tc_status     sticky completion flags, cleared by status_rd
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter  int NUM_CH = dma_pkg::NUM_CH,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] dreq,
  input  logic [NUM_CH-1:0] mask,
  input  logic              cmd_disable,
  input  logic              rotate_en,
  input  logic [NUM_CH-1:0] block_mode,
  output logic              hrq,
  input  logic              hlda,
  output logic [NUM_CH-1:0] dack,
  output logic [CH_W-1:0]   ch_sel,
  output logic              xfer_start,
  input  logic              xfer_done,
  input  logic              tc,
  input  logic              eop_n,
  output logic              busy,
  output logic [NUM_CH-1:0] tc_status,
  input  logic              status_rd
);

  arb_state_e        state, state_d;
  logic              hrq_d, xs_d;
  logic [NUM_CH-1:0] dack_d, tc_set;
  logic [CH_W-1:0]   ch_sel_d, ptr, ptr_d;
  logic              eop_seen, eop_d;
  logic              blk, blk_d;   // block_mode of the granted channel, frozen at grant

  logic [NUM_CH-1:0] eligible, grant;
  logic [CH_W-1:0]   win_idx;
  logic              win_any;

  assign eligible = dreq & ~mask;

  dma_prio_encoder #(.NUM_CH(NUM_CH)) u_prio (
    .eligible  (eligible),
    .pointer   (ptr),
    .rotate_en (rotate_en),
    .grant     (grant),
    .index     (win_idx),
    .any       (win_any)
  );

  always_comb begin
    state_d  = state;
    hrq_d    = hrq;
    dack_d   = dack;
    ch_sel_d = ch_sel;
    xs_d     = 1'b0;
    eop_d    = eop_seen;
    ptr_d    = ptr;
    blk_d    = blk;
    tc_set   = '0;
    case (state)
      ST_IDLE: begin
        if (!cmd_disable && win_any) begin
          state_d = ST_REQ;
          hrq_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (hlda) begin
          if (win_any) begin
            state_d  = ST_START;
            dack_d   = grant;
            ch_sel_d = win_idx;
            blk_d    = block_mode[win_idx];
            xs_d     = 1'b1;
          end else begin
            // Requests vanished before the bus arrived: hand it straight back.
            state_d = ST_RELEASE;
            hrq_d   = 1'b0;
          end
        end
      end
      ST_START, ST_WAIT: begin
        if (!hlda) begin
          // CPU revoked the bus: abandon the service without status or rotation.
          state_d  = ST_IDLE;
          hrq_d    = 1'b0;
          dack_d   = '0;
          ch_sel_d = '0;
          eop_d    = 1'b0;
        end else if (state == ST_START) begin
          state_d = ST_WAIT;
        end else begin
          if (!eop_n) eop_d = 1'b1;
          if (xfer_done) begin
            ptr_d = (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + 1'b1;
            if (tc || eop_seen || !eop_n) begin
              tc_set[ch_sel] = 1'b1;
              state_d  = ST_RELEASE;
              hrq_d    = 1'b0;
              dack_d   = '0;
              ch_sel_d = '0;
            end else if (blk) begin
              state_d = ST_START;
              xs_d    = 1'b1;
            end else begin
              state_d  = ST_RELEASE;
              hrq_d    = 1'b0;
              dack_d   = '0;
              ch_sel_d = '0;
            end
          end
        end
      end
      ST_RELEASE: begin
        eop_d = 1'b0;
        if (!hlda) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        hrq_d    = 1'b0;
        dack_d   = '0;
        ch_sel_d = '0;
        eop_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      hrq        <= 1'b0;
      dack       <= '0;
      ch_sel     <= '0;
      xfer_start <= 1'b0;
      eop_seen   <= 1'b0;
      ptr        <= '0;
      blk        <= 1'b0;
      tc_status  <= '0;
    end else begin
      state      <= state_d;
      hrq        <= hrq_d;
      dack       <= dack_d;
      ch_sel     <= ch_sel_d;
      xfer_start <= xs_d;
      eop_seen   <= eop_d;
      ptr        <= ptr_d;
      blk        <= blk_d;
      // A completion landing with a status read still leaves its bit set.
      tc_status  <= (tc_status & ~{NUM_CH{status_rd}}) | tc_set;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dma_channel_arbiter.sv
module tb_dma_channel_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] dreq = '0, mask = '0, block_mode = '0;
  logic         cmd_disable = 1'b0, rotate_en = 1'b0;
  logic         hlda = 1'b0, xfer_done = 1'b0, tc = 1'b0, eop_n = 1'b1, status_rd = 1'b0;
  logic         hrq, xfer_start, busy;
  logic [N-1:0] dack, tc_status;
  logic [1:0]   ch_sel;

  int n_cmp = 0;
  int n_bad = 0;

  dma_channel_arbiter dut (
    .clk(clk), .reset(reset), .dreq(dreq), .mask(mask), .cmd_disable(cmd_disable),
    .rotate_en(rotate_en), .block_mode(block_mode), .hrq(hrq), .hlda(hlda),
    .dack(dack), .ch_sel(ch_sel), .xfer_start(xfer_start), .xfer_done(xfer_done),
    .tc(tc), .eop_n(eop_n), .busy(busy), .tc_status(tc_status), .status_rd(status_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bus ownership is described by: hold requested, granted channel (-1 none),
  // whether this cycle is the start pulse, and whether the bus is being handed back.
  bit         m_hrq, m_first, m_rel, m_eop, m_blk;
  int         m_gnt, m_ptr;
  bit [N-1:0] m_tcs;

  function automatic int pick(input bit [N-1:0] e, input int base);
    for (int k = 0; k < N; k++)
      if (e[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit [N-1:0] set;
    int w;
    if (reset) begin
      m_hrq = 0; m_first = 0; m_rel = 0; m_eop = 0; m_blk = 0;
      m_gnt = -1; m_ptr = 0; m_tcs = '0;
    end else begin
      set = '0;
      if (m_rel) begin
        m_eop = 0;
        if (!hlda) m_rel = 0;
      end else if (m_gnt >= 0) begin
        if (!hlda) begin
          m_gnt = -1; m_hrq = 0; m_first = 0; m_eop = 0;
        end else if (m_first) begin
          m_first = 0;
        end else if (xfer_done) begin
          m_ptr = (m_gnt + 1) % N;
          if (tc || m_eop || !eop_n) begin
            set[m_gnt] = 1; m_gnt = -1; m_hrq = 0; m_rel = 1;
          end else if (m_blk) begin
            m_first = 1;
          end else begin
            m_gnt = -1; m_hrq = 0; m_rel = 1;
          end
        end else if (!eop_n) begin
          m_eop = 1;
        end
      end else if (m_hrq) begin
        if (hlda) begin
          w = pick(dreq & ~mask, rotate_en ? m_ptr : 0);
          if (w >= 0) begin
            m_gnt = w; m_first = 1; m_blk = block_mode[w];
          end else begin
            m_hrq = 0; m_rel = 1;
          end
        end
      end else if (!cmd_disable && (dreq & ~mask) != 0) begin
        m_hrq = 1;
      end
      if (status_rd) m_tcs = '0;
      m_tcs |= set;
    end
  end

  // Compare process: every negedge, DUT against the model.
  always @(negedge clk) begin
    chk("hrq", 32'(hrq), 32'(m_hrq));
    chk("dack", 32'(dack), (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
    if (m_gnt >= 0) chk("ch_sel", 32'(ch_sel), 32'(m_gnt));
    chk("xfer_start", 32'(xfer_start), 32'(m_first));
    chk("busy", 32'(busy), 32'(m_hrq || m_gnt >= 0 || m_rel));
    chk("tc_status", 32'(tc_status), 32'(m_tcs));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Single-mode service from IDLE with dreq already applied; checks grant literal.
  task automatic serve_single(input logic [N-1:0] exp_dack, input string nm);
    tick();                          // IDLE -> REQ
    hlda = 1; tick();                // REQ -> START
    chk({nm, "_dack"}, 32'(dack), 32'(exp_dack));
    chk({nm, "_xs"}, 32'(xfer_start), 32'd1);
    tick();                          // WAIT
    xfer_done = 1; tick(); xfer_done = 0;
    chk({nm, "_hrq_rel"}, 32'(hrq), 32'd0);
    hlda = 0; tick();                // RELEASE -> IDLE
  endtask

  initial begin
    #12 reset = 0;
    #1;
    chk("rst_hrq", 32'(hrq), 0);
    chk("rst_dack", 32'(dack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tcs", 32'(tc_status), 0);
    tick();

    // 1: fixed priority, hlda after 3 clocks
    dreq = 4'b1010; tick();
    chk("t1_hrq", 32'(hrq), 1);
    tick(); tick(); tick();
    chk("t1_nodack", 32'(dack), 0);
    hlda = 1; tick();
    chk("t1_dack", 32'(dack), 32'b0010);
    chk("t1_chsel", 32'(ch_sel), 1);
    chk("t1_xs", 32'(xfer_start), 1);
    tick();
    chk("t1_xs_pulse", 32'(xfer_start), 0);
    xfer_done = 1; tick(); xfer_done = 0;
    chk("t1_rel", 32'(dack), 0);
    hlda = 0; tick();
    chk("t1_idle", 32'(busy), 0);

    // 2: rotation (pointer now past ch1): ch3 then ch1
    rotate_en = 1;
    serve_single(4'b1000, "t2a");
    serve_single(4'b0010, "t2b");
    dreq = 0; rotate_en = 0; tick(); tick();

    // 3: block mode ch2, three transfers, tc on the last
    dreq = 4'b0100; block_mode = 4'b0100; tick();
    hlda = 1; tick();
    for (int k = 0; k < 3; k++) begin
      chk("t3_xs", 32'(xfer_start), 1);
      tick();
      chk("t3_hrq", 32'(hrq), 1);
      xfer_done = 1; tc = (k == 2); tick(); xfer_done = 0; tc = 0;
    end
    chk("t3_release", 32'(hrq), 0);
    chk("t3_tcs", 32'(tc_status), 32'b0100);
    dreq = 0; block_mode = 0; hlda = 0; tick();

    // 4: EOP in block mode ch0, status_rd coincident with completion
    dreq = 4'b0001; block_mode = 4'b0001; tick();
    hlda = 1; tick(); tick();
    eop_n = 0; tick(); eop_n = 1; tick();
    chk("t4_still_held", 32'(dack), 32'b0001);
    xfer_done = 1; status_rd = 1; tick(); xfer_done = 0; status_rd = 0;
    chk("t4_release", 32'(hrq), 0);
    chk("t4_tcs", 32'(tc_status), 32'b0001);
    dreq = 0; block_mode = 0; hlda = 0; tick();

    // 5: revoke during WAIT, then reset mid-WAIT
    dreq = 4'b0001; tick();
    hlda = 1; tick(); tick();
    hlda = 0; tick();
    chk("t5_dack", 32'(dack), 0);
    chk("t5_hrq", 32'(hrq), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_tcs", 32'(tc_status), 32'b0001);
    tick();                          // re-request
    hlda = 1; tick(); tick();
    #1 reset = 1; #1;
    chk("t5_rst_dack", 32'(dack), 0);
    chk("t5_rst_hrq", 32'(hrq), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_tcs", 32'(tc_status), 0);
    @(posedge clk); #2;
    reset = 0; hlda = 0; dreq = 0; tick();

    // 6: gating and withdrawn request
    dreq = 4'b0001; mask = 4'b0001; tick(); tick();
    chk("t6_mask", 32'(hrq), 0);
    mask = 0; cmd_disable = 1; tick(); tick();
    chk("t6_cmddis", 32'(hrq), 0);
    cmd_disable = 0; tick();
    chk("t6_hrq", 32'(hrq), 1);
    dreq = 0; tick(); tick();
    chk("t6_hold", 32'(hrq), 1);
    hlda = 1; tick();
    chk("t6_nodack", 32'(dack), 0);
    chk("t6_drop", 32'(hrq), 0);
    chk("t6_busy_rel", 32'(busy), 1);
    hlda = 0; tick();
    chk("t6_idle", 32'(busy), 0);

    // Random phase: CPU responds to hrq with random latency and occasionally revokes.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) dreq = N'($urandom);
      if ($urandom_range(0, 31) == 0) mask = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 63) == 0) block_mode = N'($urandom);
      if ($urandom_range(0, 199) == 0) rotate_en = ~rotate_en;
      cmd_disable = ($urandom_range(0, 19) == 0);
      if (hrq && !hlda && $urandom_range(0, 2) == 0) hlda = 1;
      else if (!hrq && hlda && $urandom_range(0, 1) == 0) hlda = 0;
      else if (hlda && busy && $urandom_range(0, 59) == 0) hlda = 0;
      xfer_done = ($urandom_range(0, 3) == 0);
      tc        = ($urandom_range(0, 2) == 0);
      eop_n     = ($urandom_range(0, 14) != 0);
      status_rd = ($urandom_range(0, 9) == 0);
      tick();
    end
    dreq = 0; xfer_done = 0; eop_n = 1; status_rd = 0; hlda = 0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
